// File: rtl/abc_stim_pkg.sv
// Shared types for the A/B/C stimulus sequencer: FSM states, table entry, idle vector.
package abc_stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Widest dwell a table entry can carry; instances use DWELL_W <= this
  localparam int DWELL_MAX_W = 16;

  typedef struct packed {
    logic [2:0]             vec;
    logic [DWELL_MAX_W-1:0] dwell;
  } entry_t;

  localparam logic [2:0] ABC_IDLE_VEC = 3'b000;
endpackage

// File: rtl/abc_stim_table.sv
// Step table: one synchronous write port, one asynchronous read port.
// Reset restores every entry to the idle vector with a dwell of 1.
module abc_stim_table
  import abc_stim_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [2:0]         i_wvec,
  input  logic [DWELL_W-1:0] i_wdwell,
  input  logic [AW-1:0]      i_raddr,
  output entry_t             o_rd
);
  logic [2:0]         r_vec   [DEPTH];
  logic [DWELL_W-1:0] r_dwell [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vec[i]   <= ABC_IDLE_VEC;
        r_dwell[i] <= DWELL_W'(1);
      end
    end else if (i_we) begin
      r_vec[i_waddr]   <= i_wvec;
      r_dwell[i_waddr] <= i_wdwell;
    end
  end

  assign o_rd = '{vec: r_vec[i_raddr], dwell: DWELL_MAX_W'(r_dwell[i_raddr])};
endmodule

// File: rtl/abc_stim_seq.sv
// A/B/C stimulus sequencer: plays table entries in order, each held for max(dwell,1) cycles.
// Optional ABC_STIM_LOOP_EN adds a 'loop' input that wraps the last step back to step 0.
module abc_stim_seq
  import abc_stim_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [2:0]               ld_vec,
  input  logic [DWELL_W-1:0]       ld_dwell,
  input  logic [$clog2(DEPTH):0]   num_steps,
  input  logic                     start,
`ifdef ABC_STIM_LOOP_EN
  input  logic                     loop,
`endif
  output logic [2:0]               abc,
  output logic                     sample,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     ld_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  state_t             r_state;
  logic [2:0]         r_abc;
  logic               r_sample;
  logic [AW-1:0]      r_step;
  logic               r_busy;
  logic               r_done;
  logic               r_ld_err;
  logic [DWELL_W-1:0] r_cnt;
  logic [AW:0]        r_nsteps;

  logic               w_addr_ok, w_start_ok, w_last, w_loop, w_we;
  logic [AW-1:0]      w_raddr;
  entry_t             w_rd;
  logic [DWELL_W-1:0] w_load_cnt;

`ifdef ABC_STIM_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_addr_ok  = {1'b0, ld_addr} < DEPTH_N;
  assign w_we       = ld_valid && (r_state == IDLE) && w_addr_ok;
  assign w_start_ok = start && (num_steps != '0) && (num_steps <= DEPTH_N);
  assign w_last     = {1'b0, r_step} == (r_nsteps - (AW+1)'(1));
  // Read port always points at the entry the next step change would load
  assign w_raddr    = (r_state == RUN && !w_last) ? r_step + AW'(1) : '0;
  // Cycles remaining after the first one; a dwell of 0 is treated as 1
  assign w_load_cnt = (w_rd.dwell == '0) ? '0 : w_rd.dwell[DWELL_W-1:0] - DWELL_W'(1);

  abc_stim_table #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .AW(AW)) u_table (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_wvec  (ld_vec),
    .i_wdwell(ld_dwell),
    .i_raddr (w_raddr),
    .o_rd    (w_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_abc    <= ABC_IDLE_VEC;
      r_sample <= 1'b0;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ld_err <= 1'b0;
      r_cnt    <= '0;
      r_nsteps <= '0;
    end else begin
      r_done   <= 1'b0;
      r_ld_err <= ld_valid && (r_state != IDLE || !w_addr_ok);
      case (r_state)
        IDLE: if (w_start_ok) begin
          r_state  <= RUN;
          r_nsteps <= num_steps;
          r_step   <= '0;
          r_abc    <= w_rd.vec;
          r_cnt    <= w_load_cnt;
          r_sample <= (w_load_cnt == '0);
          r_busy   <= 1'b1;
        end
        RUN: begin
          if (r_cnt != '0) begin
            r_cnt    <= r_cnt - DWELL_W'(1);
            r_sample <= (r_cnt == DWELL_W'(1));
          end else if (!w_last || w_loop) begin
            r_step   <= w_last ? '0 : r_step + AW'(1);
            r_abc    <= w_rd.vec;
            r_cnt    <= w_load_cnt;
            r_sample <= (w_load_cnt == '0);
          end else begin
            r_state  <= FIN;
            r_abc    <= ABC_IDLE_VEC;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign abc      = r_abc;
  assign sample   = r_sample;
  assign step_idx = r_step;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ld_err   = r_ld_err;
endmodule

// File: tb/tb_abc_stim_seq.sv
// Bench for abc_stim_seq: queue-based expected-output model checked every cycle,
// plus directed runs with hand-computed cycle positions. Loop test needs ABC_STIM_LOOP_EN.
module tb_abc_stim_seq;
  localparam int DEPTH = 4, DWELL_W = 8, AW = $clog2(DEPTH);

  logic clk = 1'b0, reset = 1'b1, ld_valid = 1'b0, start = 1'b0;
  logic [AW-1:0]      ld_addr = '0;
  logic [2:0]         ld_vec = '0;
  logic [DWELL_W-1:0] ld_dwell = '0;
  logic [AW:0]        num_steps = '0;
  logic [2:0]         abc;
  logic               sample, busy, done, ld_err;
  logic [AW-1:0]      step_idx;
`ifdef ABC_STIM_LOOP_EN
  logic loop = 1'b0;
`endif

  int n_tot = 0, n_bad = 0;

  always #5 clk = ~clk;

  abc_stim_seq #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_vec(ld_vec),
    .ld_dwell(ld_dwell), .num_steps(num_steps), .start(start),
`ifdef ABC_STIM_LOOP_EN
    .loop(loop),
`endif
    .abc(abc), .sample(sample), .step_idx(step_idx), .busy(busy), .done(done), .ld_err(ld_err)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]    abc;
    logic          smp;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;
  } exp_t;
  localparam exp_t E_FIN = '{abc: 3'b000, smp: 1'b0, step: '0, busy: 1'b0, done: 1'b1};

  logic [2:0] m_vec [DEPTH];
  int         m_dwell [DEPTH];
  int         m_n = 0;
  exp_t       q [$];
  exp_t       cur = '0;
  logic       e_err = 1'b0;
  logic       m_loop;

`ifdef ABC_STIM_LOOP_EN
  assign m_loop = loop;
`else
  assign m_loop = 1'b0;
`endif

  // Expand a whole run into its per-cycle outputs
  task automatic fill();
    int d;
    for (int s = 0; s < m_n; s++) begin
      d = (m_dwell[s] == 0) ? 1 : m_dwell[s];
      for (int c = 0; c < d; c++)
        q.push_back('{abc: m_vec[s], smp: (c == d-1), step: AW'(s), busy: 1'b1, done: 1'b0});
    end
  endtask

  always @(posedge clk) begin
    exp_t nxt;
    logic act;
    act = cur.busy | cur.done;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin m_vec[i] = 3'b000; m_dwell[i] = 1; end
      q.delete();
      cur   = '0;
      e_err = 1'b0;
    end else begin
      e_err = ld_valid && (act || int'(ld_addr) >= DEPTH);
      nxt = '0;
      if (cur.busy) begin
        if (q.size() > 0) nxt = q.pop_front();
        else if (m_loop) begin fill(); nxt = q.pop_front(); end
        else nxt = E_FIN;
      end else if (!cur.done && start && num_steps >= 1 && int'(num_steps) <= DEPTH) begin
        m_n = int'(num_steps);
        fill();
        nxt = q.pop_front();
      end
      if (!act && ld_valid && int'(ld_addr) < DEPTH) begin
        m_vec[ld_addr]   = ld_vec;
        m_dwell[ld_addr] = int'(ld_dwell);
      end
      cur = nxt;
    end
  end

  always @(negedge clk) begin
    logic bad;
    bad = (abc !== cur.abc) || (sample !== cur.smp) || (busy !== cur.busy) ||
          (done !== cur.done) || (ld_err !== e_err) || (cur.busy && step_idx !== cur.step);
    n_tot++;
    if (bad) begin
      n_bad++;
      $display("FAIL cycle t=%0t got abc=%b smp=%b step=%0d busy=%b done=%b err=%b want abc=%b smp=%b step=%0d busy=%b done=%b err=%b",
               $time, abc, sample, step_idx, busy, done, ld_err,
               cur.abc, cur.smp, cur.step, cur.busy, cur.done, e_err);
    end
  end

  // ---------------- directed stimulus ----------------
  int w_abc [300], w_smp [300], w_done [300], w_busy [300], w_err [300], w_step [300];

  task automatic chk(string nm, int got, int want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic int sumr(int sel, int a, int b);
    int s = 0;
    for (int c = a; c <= b; c++)
      case (sel)
        0: s += w_smp[c];
        1: s += w_done[c];
        2: s += w_busy[c];
        default: s += w_err[c];
      endcase
    return s;
  endfunction

  task automatic load(int a, logic [2:0] v, int d);
    ld_valid = 1'b1; ld_addr = AW'(a); ld_vec = v; ld_dwell = DWELL_W'(d);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic go(int n);
    num_steps = (AW+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record cycles 1..n of a run; optionally inject start+load, reset, or loop drop after cycle c
  task automatic watch(int n, int inj_c, int rst_c, int lp_c);
    for (int c = 1; c <= n; c++) begin
      w_abc[c] = int'(abc); w_smp[c] = int'(sample); w_done[c] = int'(done);
      w_busy[c] = int'(busy); w_err[c] = int'(ld_err); w_step[c] = int'(step_idx);
      start = (c == inj_c); ld_valid = (c == inj_c);
      ld_addr = '0; ld_vec = 3'b111; ld_dwell = DWELL_W'(9);
      reset = (c == rst_c);
`ifdef ABC_STIM_LOOP_EN
      if (c == lp_c) loop = 1'b0;
`else
      if (c == lp_c) start = 1'b0;
`endif
      @(negedge clk);
    end
    start = 1'b0; ld_valid = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_abc", int'(abc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_smp_err", int'({done, sample, ld_err}), 0);
    chk("rst_step", int'(step_idx), 0);
    reset = 1'b0;
    @(negedge clk);

    // three-step run: 10 + 10 + 20 cycles
    load(0, 3'b000, 10); load(1, 3'b111, 10); load(2, 3'b100, 20);
    go(3); watch(45, -1, -1, -1);
    chk("r023_smp_cnt", sumr(0, 1, 45), 3);
    chk("r023_smp_pos", w_smp[10] + w_smp[20] + w_smp[40], 3);
    chk("r023_done41", w_done[41], 1);
    chk("r023_done_cnt", sumr(1, 1, 45), 1);
    chk("r023_abc10", w_abc[10], 0);
    chk("r023_abc11", w_abc[11], 7);
    chk("r023_abc20", w_abc[20], 7);
    chk("r023_abc21", w_abc[21], 4);
    chk("r023_abc40", w_abc[40], 4);
    chk("r023_busy41", w_busy[41], 0);

    // dwell 0 behaves as 1
    load(0, 3'b101, 0); load(1, 3'b010, 1);
    go(2); watch(6, -1, -1, -1);
    chk("r024_abc1", w_abc[1], 5);
    chk("r024_abc2", w_abc[2], 2);
    chk("r024_smp12", w_smp[1] + w_smp[2], 2);
    chk("r024_done3", w_done[3], 1);

    // start and load during a run are ignored / rejected
    load(0, 3'b011, 3);
    go(2); watch(10, 1, -1, -1);
    chk("r025_err_cnt", sumr(3, 1, 10), 1);
    chk("r025_err2", w_err[2], 1);
    chk("r025_done5", w_done[5], 1);
    chk("r025_busy_after", sumr(2, 6, 10), 0);
    go(1); watch(5, -1, -1, -1);
    chk("r025_entry0_abc", w_abc[1], 3);
    chk("r025_entry0_smp3", w_smp[3], 1);
    chk("r025_done4", w_done[4], 1);

    // reset mid-run on cycle 15 of a 40-cycle run
    load(0, 3'b001, 10); load(1, 3'b010, 30);
    go(2); watch(30, -1, 15, -1);
    chk("r026_abc15", w_abc[15], 2);
    chk("r026_step15", w_step[15], 1);
    chk("r026_abc16", w_abc[16], 0);
    chk("r026_busy16", w_busy[16], 0);
    chk("r026_step16", w_step[16], 0);
    chk("r026_no_done", sumr(1, 1, 30), 0);
    go(2); watch(6, -1, -1, -1);
    chk("r026_tbl_abc", w_abc[1], 0);
    chk("r026_tbl_smp", w_smp[1] + w_smp[2], 2);
    chk("r026_tbl_done3", w_done[3], 1);

    // illegal num_steps
    go(0); watch(5, -1, -1, -1);
    chk("r027_zero_busy", sumr(2, 1, 5) + sumr(1, 1, 5), 0);
    go(DEPTH + 1); watch(5, -1, -1, -1);
    chk("r027_over_busy", sumr(2, 1, 5) + sumr(1, 1, 5), 0);

    // full depth with an all-ones dwell on the last step
    load(3, 3'b110, 255);
    go(DEPTH); watch(262, -1, -1, -1);
    chk("max_smp123", w_smp[1] + w_smp[2] + w_smp[3], 3);
    chk("max_abc4", w_abc[4], 6);
    chk("max_smp257", w_smp[257], 0);
    chk("max_smp258", w_smp[258], 1);
    chk("max_done259", w_done[259], 1);

`ifdef ABC_STIM_LOOP_EN
    load(0, 3'b101, 3); load(1, 3'b010, 3);
    loop = 1'b1;
    go(2); watch(30, -1, -1, 21);
    begin
      int mis = 0;
      for (int c = 1; c <= 15; c++) if (w_abc[c] != w_abc[c+6]) mis++;
      chk("r028_period6", mis, 0);
    end
    chk("r028_abc1", w_abc[1], 5);
    chk("r028_abc4", w_abc[4], 2);
    chk("r028_no_done", sumr(1, 1, 24), 0);
    chk("r028_done25", w_done[25], 1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
